// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite slave exposing REG_NUM 32-bit read/write registers.
// Write (AW/W/B) and read (AR/R) channels run independently.
// Optional build macro: AXI_SLAVE_ERR_RESP_EN -- out-of-range accesses
// answer SLVERR instead of OKAY (write still dropped, read data still 0).
module axi4_lite_regfile_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    REG_NUM    = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     awaddr,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [ADDR_WIDTH-1:0]     araddr,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready
);

  localparam int                    IDX_W  = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam int                    STRB_W = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] SPAN   = ADDR_WIDTH'(REG_NUM * 4);
  localparam logic [1:0]            RESP_OKAY = 2'b00;
`ifdef AXI_SLAVE_ERR_RESP_EN
  localparam logic [1:0]            RESP_OOR  = 2'b10;
`else
  localparam logic [1:0]            RESP_OOR  = 2'b00;
`endif

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_RESP} rstate_t;

  wstate_t               r_wstate, w_wstate_nxt;
  rstate_t               r_rstate, w_rstate_nxt;
  logic                  r_out_en;
  logic [DATA_WIDTH-1:0] r_mem [REG_NUM];
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic [1:0]            r_bresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [ADDR_WIDTH-1:0] w_wr_addr, w_wr_off, w_rd_off;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [STRB_W-1:0]     w_wr_strb;
  logic                  w_wr_in, w_rd_in;
  logic [IDX_W-1:0]      w_wr_idx, w_rd_idx;

  // r_out_en holds every ready low while in reset and for the reset edge itself
  assign awready = r_out_en && (r_wstate == W_IDLE || r_wstate == W_HAVE_DATA);
  assign wready  = r_out_en && (r_wstate == W_IDLE || r_wstate == W_HAVE_ADDR);
  assign bvalid  = (r_wstate == W_RESP);
  assign bresp   = bvalid ? r_bresp : '0;
  assign arready = r_out_en && (r_rstate == R_IDLE);
  assign rvalid  = (r_rstate == R_RESP);
  assign rresp   = rvalid ? r_rresp : '0;
  assign rdata   = r_rdata;

  assign w_aw_hs = awvalid && awready;
  assign w_w_hs  = wvalid  && wready;
  assign w_ar_hs = arvalid && arready;

  // The half that arrives on the commit edge comes straight from the bus,
  // the half that arrived earlier comes from its holding register.
  assign w_wr_addr = w_aw_hs ? awaddr : r_awaddr;
  assign w_wr_data = w_w_hs  ? wdata  : r_wdata;
  assign w_wr_strb = w_w_hs  ? wstrb  : r_wstrb;
  assign w_wr_off  = w_wr_addr - BASE_ADDR;
  assign w_wr_in   = (w_wr_off < SPAN);
  assign w_wr_idx  = IDX_W'(w_wr_off >> 2);
  assign w_rd_off  = araddr - BASE_ADDR;
  assign w_rd_in   = (w_rd_off < SPAN);
  assign w_rd_idx  = IDX_W'(w_rd_off >> 2);
  assign w_commit  = (r_wstate != W_RESP) && (w_wstate_nxt == W_RESP);

  // Write FSM next-state logic
  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) w_wstate_nxt = W_RESP;
        else if (w_aw_hs)      w_wstate_nxt = W_HAVE_ADDR;
        else if (w_w_hs)       w_wstate_nxt = W_HAVE_DATA;
      end
      W_HAVE_ADDR: if (w_w_hs)  w_wstate_nxt = W_RESP;
      W_HAVE_DATA: if (w_aw_hs) w_wstate_nxt = W_RESP;
      W_RESP:      if (bready)  w_wstate_nxt = W_IDLE;
      default:                  w_wstate_nxt = W_IDLE;
    endcase
  end

  // Read FSM next-state logic
  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_RESP;
      R_RESP:  if (rready)  w_rstate_nxt = R_IDLE;
      default:              w_rstate_nxt = R_IDLE;
    endcase
  end

  // State registers and ready enable
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
      r_out_en <= 1'b0;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
      r_out_en <= 1'b1;
    end
  end

  // Hold whichever write half arrives first; capture the B response on commit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bresp  <= '0;
    end else begin
      if (w_aw_hs) r_awaddr <= awaddr;
      if (w_w_hs) begin
        r_wdata <= wdata;
        r_wstrb <= wstrb;
      end
      if (w_commit) r_bresp <= w_wr_in ? RESP_OKAY : RESP_OOR;
    end
  end

  // Register array: bytewise update on commit, out-of-range writes dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_NUM; i++) r_mem[i] <= '0;
    end else if (w_commit && w_wr_in) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (w_wr_strb[b]) r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
      end
    end
  end

  // Read data capture; a same-edge write is not yet visible, so the old value returns
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
      r_rresp <= '0;
    end else if (w_ar_hs) begin
      r_rdata <= w_rd_in ? r_mem[w_rd_idx] : '0;
      r_rresp <= w_rd_in ? RESP_OKAY : RESP_OOR;
    end
  end

endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// Self-checking bench for axi4_lite_regfile_slave: directed cases plus a
// randomized mix checked against a register-array reference model.
module tb_axi4_lite_regfile_slave;

  localparam int NREG = 64;
`ifdef AXI_SLAVE_ERR_RESP_EN
  localparam logic [1:0] OOR = 2'b10;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif

  logic        clk, rst;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int checks   = 0;
  int failures = 0;
  logic [31:0] model [NREG];

  axi4_lite_regfile_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_NUM(NREG), .BASE_ADDR(32'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return a < NREG * 4;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'(a / 4);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) model[i] = 32'h0;
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    mask = 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) mask = mask | (32'hFF << (8 * b));
    if (in_range(a)) model[idx_of(a)] = (model[idx_of(a)] & ~mask) | (d & mask);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, awready, 0);
    check({tag, "_wready"},  wready,  0);
    check({tag, "_bvalid"},  bvalid,  0);
    check({tag, "_bresp"},   bresp,   0);
    check({tag, "_arready"}, arready, 0);
    check({tag, "_rvalid"},  rvalid,  0);
    check({tag, "_rdata"},   rdata,   0);
    check({tag, "_rresp"},   rresp,   0);
  endtask

  // Write with AW/W offered after independent delays and B held off b_dly cycles
  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done = 0, w_done = 0, hs_aw, hs_w;
    int cyc = 0;
    logic [1:0] exp_resp;
    exp_resp = in_range(addr) ? 2'b00 : OOR;
    while (!(aw_done && w_done)) begin
      awaddr  = addr;  wdata = data;  wstrb = strb;
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done  && (cyc >= w_dly);
      if (aw_done) check("aw_blocked", awready, 0);
      if (w_done)  check("w_blocked",  wready,  0);
      hs_aw = awvalid && awready;
      hs_w  = wvalid  && wready;
      tick();
      cyc++;
      if (hs_aw) aw_done = 1;
      if (hs_w)  w_done  = 1;
      if (!(aw_done && w_done)) check("bvalid_early", bvalid, 0);
      if (cyc > 30) begin
        check("wr_timeout", 0, 1);
        awvalid = 0; wvalid = 0;
        return;
      end
    end
    awvalid = 0; wvalid = 0;
    model_write(addr, data, strb);
    check("bvalid", bvalid, 1);
    check("bresp", bresp, exp_resp);
    for (int i = 0; i < b_dly; i++) begin
      awvalid = 1; wvalid = 1;
      tick();
      check("bvalid_hold", bvalid, 1);
      check("bresp_hold", bresp, exp_resp);
      check("awready_in_resp", awready, 0);
      check("wready_in_resp", wready, 0);
    end
    awvalid = 0; wvalid = 0;
    bready = 1;
    tick();
    bready = 0;
    check("bvalid_clear", bvalid, 0);
    check("bresp_clear", bresp, 0);
  endtask

  // Read with R held off r_dly cycles
  task automatic rd(input logic [31:0] addr, input int r_dly);
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    int cyc = 0;
    araddr = addr;
    arvalid = 1;
    while (!arready) begin
      tick();
      cyc++;
      if (cyc > 30) begin
        check("rd_timeout", 0, 1);
        arvalid = 0;
        return;
      end
    end
    exp_data = in_range(addr) ? model[idx_of(addr)] : 32'h0;
    exp_resp = in_range(addr) ? 2'b00 : OOR;
    tick();
    arvalid = 0;
    check("rvalid", rvalid, 1);
    check("rdata", rdata, exp_data);
    check("rresp", rresp, exp_resp);
    for (int i = 0; i < r_dly; i++) begin
      arvalid = 1;
      tick();
      check("rvalid_hold", rvalid, 1);
      check("rdata_hold", rdata, exp_data);
      check("arready_in_resp", arready, 0);
    end
    arvalid = 0;
    rready = 1;
    tick();
    rready = 0;
    check("rvalid_clear", rvalid, 0);
    check("rresp_clear", rresp, 0);
  endtask

  initial begin
    logic [31:0] a, d, old10;
    rst = 1; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arvalid = 0; rready = 0;
    model_clear();

    // Reset state
    tick();
    tick();
    check_all_zero("reset");
    rst = 0;
    tick();
    check("post_rst_awready", awready, 1);
    check("post_rst_wready",  wready,  1);
    check("post_rst_arready", arready, 1);

    // Basic write/read, partial strobe, decoupled channels with backpressure
    wr(32'h04, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    rd(32'h04, 0);
    wr(32'h08, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    wr(32'h08, 32'h12345678, 4'b0101, 0, 0, 0);
    rd(32'h08, 0);
    wr(32'h0C, 32'hDEADBEEF, 4'hF, 0, 3, 5);
    wr(32'h14, 32'h0BADF00D, 4'hF, 3, 0, 0);
    rd(32'h0C, 4);
    rd(32'h14, 0);

    // Read handshake on the same edge as a write commit to the same register
    old10 = model[4];
    awaddr = 32'h10; wdata = 32'hABABABAB; wstrb = 4'hF; araddr = 32'h10;
    awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
    check("coll_awready", awready, 1);
    check("coll_arready", arready, 1);
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    check("coll_bvalid", bvalid, 1);
    check("coll_rvalid", rvalid, 1);
    check("coll_rdata_old", rdata, old10);
    model_write(32'h10, 32'hABABABAB, 4'hF);
    tick();
    bready = 0; rready = 0;
    check("coll_bvalid_clear", bvalid, 0);
    check("coll_rvalid_clear", rvalid, 0);
    rd(32'h10, 0);

    // Out of range: write dropped (no aliasing onto register 0), read returns 0
    wr(32'h200, 32'h11223344, 4'hF, 0, 0, 0);
    rd(32'h200, 0);
    rd(32'h000, 0);
    rd(32'hFFFF_FFFC, 1);

    // Randomized mix against the model
    for (int n = 0; n < 80; n++) begin
      a = 32'($urandom_range(0, 32'h23F));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        wr(a, d, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end else begin
        rd(a, int'($urandom_range(0, 3)));
      end
    end

    // Reset while a write waits for data and a read response is pending
    awaddr = 32'h04; awvalid = 1; araddr = 32'h08; arvalid = 1;
    tick();
    awvalid = 0; arvalid = 0;
    check("mid_awready", awready, 0);
    check("mid_wready", wready, 1);
    check("mid_rvalid", rvalid, 1);
    rst = 1; wvalid = 1; wdata = 32'h55555555; wstrb = 4'hF;
    tick();
    check_all_zero("mid_reset");
    rst = 0; wvalid = 0;
    model_clear();
    tick();
    check("mid_post_awready", awready, 1);
    rd(32'h04, 0);
    rd(32'h08, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4_lite_regfile_slave.md
Name: axi4_lite_regfile_slave

Overview:
AXI4-Lite responder that terminates one slave port of the peripheral interconnect and exposes a bank of REG_NUM 32-bit read/write registers. Write and read channels run independently: AW and W are accepted in any order, and each transaction gets one B or R beat. This block is the standard slave instance behind each decoded 0x100 window of the peripheral address map.

Parameters:
ADDR_WIDTH, 32, width of awaddr/araddr
DATA_WIDTH, 32, data width; only 32 is supported (4 strobe bits)
REG_NUM, 64, number of word registers (64 words = 0x100 bytes)
BASE_ADDR, 32'h0, byte address of register 0; decode uses offset = addr - BASE_ADDR

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
awaddr  in  ADDR_WIDTH  write address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte strobes
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  write response ready
araddr  in  ADDR_WIDTH  read address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  DATA_WIDTH  read data
rresp  out  2  read response
rvalid  out  1  read response valid
rready  in  1  read response ready

Behaviour:
- Reset (rst=1 at an edge): every output is 0; all registers are cleared to 0; both FSMs go to IDLE. awready, wready and arready rise to 1 in the first cycle after rst falls. A reset asserted mid-transaction aborts it: valids drop and no register is written.
- Decode: index = offset[ADDR_WIDTH-1:2]; address bits [1:0] are ignored; in range iff offset < REG_NUM*4.
- Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
  - W_IDLE: awready=1 and wready=1. AW and W handshaking on the same edge go to W_RESP. AW alone goes to W_HAVE_ADDR. W alone goes to W_HAVE_DATA.
  - W_HAVE_ADDR: awready=0, wready=1. Waits for W, then goes to W_RESP.
  - W_HAVE_DATA: awready=1, wready=0. Waits for AW, then goes to W_RESP.
  - Commit edge: on the edge where the second of AW/W handshakes, the register is updated bytewise per wstrb (strobe 0 keeps the old byte), and bvalid=1 is set. The new value is visible from that edge.
  - W_RESP: awready=0, wready=0; bvalid and bresp are held stable until bready=1, then the FSM returns to W_IDLE. Back-to-back rate is one write every 2 cycles when bready is tied high.
- Read FSM states: R_IDLE, R_RESP.
  - R_IDLE: arready=1. On the AR handshake edge, rdata is loaded from the array, rvalid=1 is set, and the FSM goes to R_RESP. Latency is 1 cycle.
  - R_RESP: arready=0; rdata, rresp and rvalid are held until rready=1, then the FSM returns to R_IDLE.
- Collision: if the AR handshake lands on the same edge as a write commit to the same index, rdata returns the pre-write value.
- Responses: OKAY=2'b00 for in-range accesses. Out-of-range writes are dropped; out-of-range reads return rdata=0. The response code for out-of-range accesses is set by the optional feature.
- bresp and rresp read 0 whenever their valid is 0.

Optional Feature:
AXI_SLAVE_ERR_RESP_EN
- Defined: out-of-range accesses return SLVERR=2'b10 on bresp/rresp. The write is still dropped and rdata is still 0.
- Undefined: out-of-range accesses return OKAY=2'b00, silently dropped or read as 0.

Test Plan:
- Basic write/read: AW+W together, addr 0x04, data 0xAABBCCDD, wstrb 4'hF, bready=1 -> bvalid one cycle later with bresp 0. Then AR 0x04 -> rvalid next cycle with rdata 0xAABBCCDD, rresp 0.
- Partial strobe: write 0xFFFFFFFF to 0x08, then 0x12345678 with wstrb 4'b0101 -> read of 0x08 returns 0xFF34FF78.
- Decoupled channels and backpressure:
  - AW 0x0C, then W 0xDEADBEEF 3 cycles later -> awready=0 while waiting; bvalid only after W.
  - Hold bready=0 for 5 cycles -> bvalid and bresp stable; no new AW/W accepted until the B handshake.
- Read backpressure and collision:
  - Read with rready=0 for 4 cycles -> rdata held and arready=0.
  - AR 0x10 on the same edge as a write commit of 0xABABABAB to 0x10 (old value 0) -> rdata=0; the next read returns 0xABABABAB.
- Out of range (REG_NUM=64): write 0x200 and read 0x200 -> rdata=0 and no register changes. Response is 2'b10 with AXI_SLAVE_ERR_RESP_EN defined, 2'b00 without.
- Reset mid-op: assert rst while in W_HAVE_ADDR and with rvalid=1 -> next cycle all outputs are 0. Reading 0x04 afterwards returns 0.
